// File: rtl/int_rti_pkg.sv
// ---------------------------------------------------------------------------
// int_rti_pkg
// Shared definitions for the interrupt entry / return-from-interrupt
// sequencer: the reset value of the data-memory stack pointer, the
// sequencer state encoding and a helper that selects one half of a PC.
//
// Optional feature macro: INT_SAVE_FLAGS_EN adds the flag push/pop states.
// ---------------------------------------------------------------------------
package int_rti_pkg;

   // Stack pointer value after reset (top of the data-memory stack)
   localparam logic [15:0] SP_RESET_DEFAULT = 16'h0FFF;

   // One state per cycle of the entry and return sequences
   typedef enum logic [3:0] {
      IDLE,
      PUSH_HI,
      PUSH_LO,
`ifdef INT_SAVE_FLAGS_EN
      PUSH_FLG,
      POP_FLG_RD,
      POP_FLG_WR,
`endif
      VECTOR,
      POP_LO_RD,
      POP_LO_WR,
      POP_HI_RD,
      POP_HI_WR
   } seq_state_e;

   // Returns PC[31:16] when hi is set, otherwise PC[15:0]
   function automatic logic [15:0] pcHalf(input logic [31:0] pc, input logic hi);
      pcHalf = hi ? pc[31:16] : pc[15:0];
   endfunction

endpackage

// File: rtl/int_rti_sequencer_if.sv
// ---------------------------------------------------------------------------
// int_rti_sequencer_if
// Data-memory bus used by the sequencer to push and pop the saved PC.
//   memRead / memWrite : strobes, driven by the master
//   memAddr            : address, ADDR_W bits, driven by the master
//   memWdata           : write data, driven by the master
//   memRdata           : read data, valid the cycle after memRead, driven
//                        by the slave (the memory)
// ---------------------------------------------------------------------------
interface int_rti_sequencer_if #(
   parameter int ADDR_W = 16
);

   logic              memRead;
   logic              memWrite;
   logic [ADDR_W-1:0] memAddr;
   logic [15:0]       memWdata;
   logic [15:0]       memRdata;

   // Sequencer side
   modport master (
      output memRead,
      output memWrite,
      output memAddr,
      output memWdata,
      input  memRdata
   );

   // Memory side
   modport slave (
      input  memRead,
      input  memWrite,
      input  memAddr,
      input  memWdata,
      output memRdata
   );

endinterface

// File: rtl/int_stack_ptr.sv
// ---------------------------------------------------------------------------
// int_stack_ptr
// Data-memory stack pointer. Decrements on a push, increments on a pop,
// wraps modulo 2^ADDR_W with no overflow/underflow detection.
//   clk : clock, rising edge
//   Rst : synchronous active-high reset, loads SP_RESET
//   inc : pop this cycle  (sp <= sp + 1)
//   dec : push this cycle (sp <= sp - 1)
//   sp  : current stack pointer
// ---------------------------------------------------------------------------
module int_stack_ptr #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              inc,
   input  logic              dec,
   output logic [ADDR_W-1:0] sp
);

   // inc and dec are never requested together by the sequencer; if they
   // ever were, the pointer is left unchanged.
   always_ff @(posedge clk) begin
      if (Rst) begin
         sp <= SP_RESET;
      end else if (inc && !dec) begin
         sp <= sp + ADDR_W'(1);
      end else if (dec && !inc) begin
         sp <= sp - ADDR_W'(1);
      end
   end

endmodule

// File: rtl/int_rti_sequencer.sv
// ---------------------------------------------------------------------------
// int_rti_sequencer
// Interrupt entry / RTI sequencer. On an accepted interrupt it pushes the
// 32-bit PC onto the data-memory stack (high half first) and pulses
// startINT to load vector 0. On RTI it pops the low half then the high
// half and hands each to the PC through writePcLow / writePcHigh.
//
// Ports:
//   clk, Rst          : clock (rising edge), synchronous active-high reset
//   intReq, rtiReq    : level requests; interrupt wins when both are high
//   pcIn              : PC to save on interrupt entry
//   mem               : data-memory bus (master side)
//   INTStall          : hold the PC while a sequence runs
//   startINT          : one-cycle pulse, load interrupt vector 0
//   writePcHigh/Low   : load returnAddress into PC[31:16] / PC[15:0]
//   returnAddress     : restored PC half, 0 when neither write is active
//   busy              : high in every non-IDLE state
//
// Optional feature macro INT_SAVE_FLAGS_EN: also pushes flagsIn after the
// PC and restores it first on return through flagsOut / flagsWrite.
// ---------------------------------------------------------------------------
module int_rti_sequencer
   import int_rti_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_DEFAULT)
) (
   input  logic                       clk,
   input  logic                       Rst,
   input  logic                       intReq,
   input  logic                       rtiReq,
   input  logic [31:0]                pcIn,
   int_rti_sequencer_if.master        mem,
`ifdef INT_SAVE_FLAGS_EN
   input  logic [3:0]                 flagsIn,
   output logic [3:0]                 flagsOut,
   output logic                       flagsWrite,
`endif
   output logic                       INTStall,
   output logic                       startINT,
   output logic                       writePcHigh,
   output logic                       writePcLow,
   output logic [15:0]                returnAddress,
   output logic                       busy
);

   seq_state_e        state;
   logic [31:0]       savedPc;
   logic [ADDR_W-1:0] sp;

   // The stack pointer moves in exactly the cycles that touch memory:
   // down after each write, up with each read.
   int_stack_ptr #(
      .ADDR_W   (ADDR_W),
      .SP_RESET (SP_RESET)
   ) stackPtr (
      .clk (clk),
      .Rst (Rst),
      .inc (mem.memRead),
      .dec (mem.memWrite),
      .sp  (sp)
   );

   // Sequencer. Strobes, address and write data are registered together
   // with the state they belong to, so each is computed from the SP value
   // that will be current once the new state is entered: a push following
   // another push uses sp-1, a pop read uses sp+1.
   always_ff @(posedge clk) begin
      if (Rst) begin
         state        <= IDLE;
         savedPc      <= '0;
         mem.memRead  <= 1'b0;
         mem.memWrite <= 1'b0;
         mem.memAddr  <= '0;
         mem.memWdata <= '0;
         startINT     <= 1'b0;
         writePcLow   <= 1'b0;
         writePcHigh  <= 1'b0;
`ifdef INT_SAVE_FLAGS_EN
         flagsWrite   <= 1'b0;
`endif
      end else begin
         mem.memRead  <= 1'b0;
         mem.memWrite <= 1'b0;
         mem.memAddr  <= '0;
         mem.memWdata <= '0;
         startINT     <= 1'b0;
         writePcLow   <= 1'b0;
         writePcHigh  <= 1'b0;
`ifdef INT_SAVE_FLAGS_EN
         flagsWrite   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (intReq) begin
                  savedPc      <= pcIn;
                  state        <= PUSH_HI;
                  mem.memWrite <= 1'b1;
                  mem.memAddr  <= sp;
                  mem.memWdata <= pcHalf(pcIn, 1'b1);
               end else if (rtiReq) begin
`ifdef INT_SAVE_FLAGS_EN
                  state        <= POP_FLG_RD;
`else
                  state        <= POP_LO_RD;
`endif
                  mem.memRead  <= 1'b1;
                  mem.memAddr  <= sp + ADDR_W'(1);
               end
            end
            PUSH_HI: begin
               state        <= PUSH_LO;
               mem.memWrite <= 1'b1;
               mem.memAddr  <= sp - ADDR_W'(1);
               mem.memWdata <= pcHalf(savedPc, 1'b0);
            end
            PUSH_LO: begin
`ifdef INT_SAVE_FLAGS_EN
               state        <= PUSH_FLG;
               mem.memWrite <= 1'b1;
               mem.memAddr  <= sp - ADDR_W'(1);
               mem.memWdata <= {12'b0, flagsIn};
`else
               state        <= VECTOR;
               startINT     <= 1'b1;
`endif
            end
`ifdef INT_SAVE_FLAGS_EN
            PUSH_FLG: begin
               state    <= VECTOR;
               startINT <= 1'b1;
            end
            POP_FLG_RD: begin
               state      <= POP_FLG_WR;
               flagsWrite <= 1'b1;
            end
            POP_FLG_WR: begin
               state       <= POP_LO_RD;
               mem.memRead <= 1'b1;
               mem.memAddr <= sp + ADDR_W'(1);
            end
`endif
            VECTOR: begin
               state <= IDLE;
            end
            POP_LO_RD: begin
               state      <= POP_LO_WR;
               writePcLow <= 1'b1;
            end
            POP_LO_WR: begin
               state       <= POP_HI_RD;
               mem.memRead <= 1'b1;
               mem.memAddr <= sp + ADDR_W'(1);
            end
            POP_HI_RD: begin
               state       <= POP_HI_WR;
               writePcHigh <= 1'b1;
            end
            POP_HI_WR: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Read data only arrives in the cycle after the read strobe, so the
   // restored value is steered from memRdata under the registered write
   // enables rather than registered itself.
   assign returnAddress = (writePcLow || writePcHigh) ? mem.memRdata : 16'h0000;
`ifdef INT_SAVE_FLAGS_EN
   assign flagsOut      = flagsWrite ? mem.memRdata[3:0] : 4'h0;
`endif

   // Busy and stall cover VECTOR too; startINT takes priority downstream.
   assign busy     = (state != IDLE);
   assign INTStall = busy;

endmodule
